// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle two's-complement adder that consumes DIGIT
// bits per clock. It returns the WIDTH-bit sum, the carry-out and the signed
// overflow. Operands and results each move through a valid/ready handshake.
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_shifted;
  logic [WIDTH-1:0] digit_top;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic [DIGIT:0]   digit_sum;
  logic             msb_cin;
  logic             accept;
  logic             last;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

  // Digit adder. It also produces the next sum-register value, with the new
  // digit entering from the top.
  always_comb begin
    digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // The carry into the digit MSB is recovered as s ^ a ^ b at that bit.
    // This covers DIGIT = 1 (where it equals the carry register) without a
    // separate narrower adder.
    msb_cin = digit_sum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    digit_top = '0;
    digit_top[WIDTH-1 -: DIGIT] = digit_sum[DIGIT-1:0];
    sum_shifted = (sum_r >> DIGIT) | digit_top;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs. in_ready is held low during reset.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          state_next = ADD;
        end
      end
      ADD: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, and process one digit per ADD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        ADD: begin
          sum_r <= sum_shifted;
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= digit_sum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout_r <= digit_sum[DIGIT];
            ovf_r  <= msb_cin ^ digit_sum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder. It exercises five width/digit configurations
// against an arithmetic reference model, using directed table vectors and
// hand-written handshake, back-pressure and reset sequences.
module tb_serial_chunk_adder;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           cin_bus;
  logic           out_ready;
  logic [31:0]    a_bus;
  logic [31:0]    b_bus;
  logic [NI-1:0]  iv;
  logic [NI-1:0]  ir;
  logic [NI-1:0]  ovl;
  logic [NI-1:0]  co;
  logic [NI-1:0]  of;
  logic [7:0]     s0;
  logic [7:0]     s1;
  logic [7:0]     s2;
  logic [15:0]    s3;
  logic [31:0]    s4;

  int vectors     = 0;
  int miscompares = 0;

  serial_chunk_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin_bus),
    .out_valid(ovl[0]), .out_ready(out_ready), .sum(s0), .cout(co[0]), .ovf(of[0]));

  serial_chunk_adder #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin_bus),
    .out_valid(ovl[1]), .out_ready(out_ready), .sum(s1), .cout(co[1]), .ovf(of[1]));

  serial_chunk_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin_bus),
    .out_valid(ovl[2]), .out_ready(out_ready), .sum(s2), .cout(co[2]), .ovf(of[2]));

  serial_chunk_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
    .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin_bus),
    .out_valid(ovl[3]), .out_ready(out_ready), .sum(s3), .cout(co[3]), .ovf(of[3]));

  serial_chunk_adder #(.WIDTH(32), .DIGIT(32)) u_w32d32 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]),
    .a(a_bus), .b(b_bus), .cin(cin_bus),
    .out_valid(ovl[4]), .out_ready(out_ready), .sum(s4), .cout(co[4]), .ovf(of[4]));

  function automatic int w_of(input int k);
    case (k)
      0, 1, 2: return 8;
      3:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int d_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2, 3:    return 4;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] sum_of(input int k);
    case (k)
      0:       return {24'd0, s0};
      1:       return {24'd0, s1};
      2:       return {24'd0, s2};
      3:       return {16'd0, s3};
      default: return s4;
    endcase
  endfunction

  // Reference: unsigned sum for sum/cout, and true signed sum range test for ovf.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic c, output logic [31:0] s, output logic cy,
                                output logic ov);
    longint unsigned full, half, ua, ub, tot;
    longint sa, sb, st;
    full = 64'd1 << w;
    half = full >> 1;
    ua   = {32'd0, a} & (full - 1);
    ub   = {32'd0, b} & (full - 1);
    tot  = ua + ub + {63'd0, c};
    s    = 32'(tot & (full - 1));
    cy   = (tot >= full);
    sa   = (ua >= half) ? longint'(ua) - longint'(full) : longint'(ua);
    sb   = (ub >= half) ? longint'(ub) - longint'(full) : longint'(ub);
    st   = sa + sb + longint'({63'd0, c});
    ov   = (st >= longint'(half)) || (st < -longint'(half));
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One full transaction on instance k. stall < 0 raises out_ready from the
  // accept onward. Otherwise the bench waits stall cycles in DONE first.
  task automatic run_add(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [31:0] es, input logic eco,
                         input logic eov, input int stall, input string tag);
    int n;
    int lat;
    bit seen;
    logic [31:0] gs;
    logic gco, gov;
    n = w_of(k) / d_of(k);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (ir[k]) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check($sformatf("%s in_ready before accept", tag), {63'd0, seen}, 64'd1);
    if (!seen) return;
    a_bus = a; b_bus = b; cin_bus = c; iv[k] = 1'b1;
    out_ready = (stall < 0);
    @(posedge clk); #1;
    iv[k] = 1'b0;
    a_bus = $urandom; b_bus = $urandom; cin_bus = 1'($urandom_range(0, 1));
    seen = 0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ovl[k]) begin
        seen = 1;
        break;
      end
    end
    check($sformatf("%s latency", tag), 64'(lat), 64'(n));
    if (!seen) begin
      out_ready = 1'b0;
      return;
    end
    gs = sum_of(k); gco = co[k]; gov = of[k];
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
      end
      check($sformatf("%s sum held", tag), {32'd0, sum_of(k)}, {32'd0, gs});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("%s sum", tag),  {32'd0, gs}, {32'd0, es});
    check($sformatf("%s cout", tag), {63'd0, gco}, {63'd0, eco});
    check($sformatf("%s ovf", tag),  {63'd0, gov}, {63'd0, eov});
    check($sformatf("%s in_ready after consume", tag), {63'd0, ir[k]}, 64'd1);
    check($sformatf("%s out_valid after consume", tag), {63'd0, ovl[k]}, 64'd0);
  endtask

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] es;
    logic        eco;
    logic        eov;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, es;
    logic rc, eco, eov;
    int cfgs[4];
    bit seen;

    tbl[0] = '{0, 32'hFF,       32'h01, 1'b0, 32'h00,       1'b1, 1'b0};
    tbl[1] = '{0, 32'h7F,       32'h01, 1'b0, 32'h80,       1'b0, 1'b1};
    tbl[2] = '{0, 32'h80,       32'h80, 1'b0, 32'h00,       1'b1, 1'b1};
    tbl[3] = '{2, 32'hA5,       32'h5A, 1'b1, 32'h00,       1'b1, 1'b0};
    tbl[4] = '{1, 32'h03,       32'h04, 1'b0, 32'h07,       1'b0, 1'b0};
    tbl[5] = '{4, 32'hFFFFFFFF, 32'h00, 1'b1, 32'h00,       1'b1, 1'b0};
    tbl[6] = '{4, 32'h7FFFFFFF, 32'h00, 1'b1, 32'h80000000, 1'b0, 1'b1};
    tbl[7] = '{3, 32'h8000,     32'h8000, 1'b0, 32'h0000,   1'b1, 1'b1};
    tbl[8] = '{3, 32'h1234,     32'h4321, 1'b0, 32'h5555,   1'b0, 1'b0};

    rst = 1'b1; iv = '0; out_ready = 1'b0;
    a_bus = '0; b_bus = '0; cin_bus = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset[%0d] in_ready during rst", k), {63'd0, ir[k]}, 64'd0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset[%0d] in_ready", k),  {63'd0, ir[k]},  64'd1);
      check($sformatf("reset[%0d] out_valid", k), {63'd0, ovl[k]}, 64'd0);
      check($sformatf("reset[%0d] sum", k),       {32'd0, sum_of(k)}, 64'd0);
      check($sformatf("reset[%0d] cout", k),      {63'd0, co[k]},  64'd0);
      check($sformatf("reset[%0d] ovf", k),       {63'd0, of[k]},  64'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_add(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].es, tbl[i].eco, tbl[i].eov,
              0, $sformatf("tbl%0d", i));
    end

    // Back-pressure: DONE held 5 cycles with in_valid pulses that must be ignored.
    a_bus = 32'h7F; b_bus = 32'h01; cin_bus = 1'b0; iv[0] = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ovl[0]) begin
        seen = 1;
        break;
      end
    end
    check("bp reached DONE", {63'd0, seen}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d out_valid", i), {63'd0, ovl[0]}, 64'd1);
      check($sformatf("bp%0d sum", i),       {56'd0, s0}, 64'h80);
      check($sformatf("bp%0d cout", i),      {63'd0, co[0]}, 64'd0);
      check($sformatf("bp%0d ovf", i),       {63'd0, of[0]}, 64'd1);
      check($sformatf("bp%0d in_ready", i),  {63'd0, ir[0]}, 64'd0);
      iv[0] = i[0]; a_bus = 32'h11; b_bus = 32'h22;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp consume out_valid", {63'd0, ovl[0]}, 64'd0);
    check("bp consume in_ready",  {63'd0, ir[0]},  64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp no extra accept in_ready", {63'd0, ir[0]},  64'd1);
    check("bp no extra transfer",        {63'd0, ovl[0]}, 64'd0);

    // Reset in the middle of ADD, with the counter at 3.
    a_bus = 32'h55; b_bus = 32'h22; cin_bus = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst in_ready low in rst", {63'd0, ir[0]}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst in_ready",  {63'd0, ir[0]},  64'd1);
    check("midrst out_valid", {63'd0, ovl[0]}, 64'd0);
    check("midrst sum",       {56'd0, s0},     64'd0);
    check("midrst cout",      {63'd0, co[0]},  64'd0);
    run_add(0, 32'h03, 32'h04, 1'b0, 32'h07, 1'b0, 1'b0, 0, "after midrst");

    // Random sweep over (8,1), (8,2), (16,4) and (32,32) with varied back-pressure.
    cfgs = '{0, 1, 3, 4};
    foreach (cfgs[ci]) begin
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        model(w_of(cfgs[ci]), ra, rb, rc, es, eco, eov);
        run_add(cfgs[ci], ra, rb, rc, es, eco, eov, int'($urandom_range(0, 3)) - 1,
                $sformatf("rnd k%0d #%0d", cfgs[ci], i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
